// File: rtl/intack_master_pkg.sv
// Shared definitions for the 8259 interrupt-acknowledge initiator and the PIC benches.
package intack_master_pkg;

  localparam int DATA_W              = 8;
  localparam int INTA_LOW_CYCLES_DEF = 2;
  localparam int INTA_GAP_CYCLES_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PULSE1,
    ST_GAP,
    ST_PULSE2,
    ST_HOLD,
    ST_RECOVER
  } intack_state_e;

  // Width of the shared down-counter: it must hold the longest state duration,
  // which is either a low pulse or the post-sequence recovery (gap + 2).
  function automatic int cnt_width(input int low, input int gap);
    int m;
    m = (low > gap + 2) ? low : gap + 2;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous PIC pins; both flops clear on reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;

  // Metastability chain: first flop catches the async level, second one settles it.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/intack_master.sv
// CPU-side 8259 INTA initiator: issues the two-pulse acknowledge, captures the
// vector during the second pulse and hands it to the core over valid/ready.
module intack_master
  import intack_master_pkg::*;
#(
  parameter int INTA_LOW_CYCLES = INTA_LOW_CYCLES_DEF,
  parameter int INTA_GAP_CYCLES = INTA_GAP_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              int_req,
  input  logic              int_enable,
  input  logic [DATA_W-1:0] data_in,
  output logic              inta_n,
  output logic [DATA_W-1:0] vector_out,
  output logic              vector_valid,
  input  logic              vector_ready,
  output logic              spurious,
  output logic              busy
);

  localparam int               CNT_W  = cnt_width(INTA_LOW_CYCLES, INTA_GAP_CYCLES);
  localparam logic [CNT_W-1:0] LOW_LD = CNT_W'(INTA_LOW_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(INTA_GAP_CYCLES);
  localparam logic [CNT_W-1:0] REC_LD = CNT_W'(INTA_GAP_CYCLES + 2);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  intack_state_e     state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              inta_n_nxt;
  logic [DATA_W-1:0] vector_nxt;
  logic              valid_nxt;
  logic              spurious_nxt;
  logic              int_sync;
  logic              cnt_last;

  sync_2ff #(.WIDTH(1)) u_int_sync (
    .clk   (clk),
    .reset (reset),
    .d     (int_req),
    .q     (int_sync)
  );

  assign cnt_last = (cnt == ONE);
  assign busy     = (state != ST_IDLE);

  // State, counter and all outputs are registered so inta_n is glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      inta_n       <= 1'b1;
      vector_out   <= '0;
      vector_valid <= 1'b0;
      spurious     <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      inta_n       <= inta_n_nxt;
      vector_out   <= vector_nxt;
      vector_valid <= valid_nxt;
      spurious     <= spurious_nxt;
    end
  end

  // Sequencer: once PULSE1 starts, both pulses always complete regardless of INT/enable.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    inta_n_nxt   = inta_n;
    vector_nxt   = vector_out;
    valid_nxt    = vector_valid;
    spurious_nxt = spurious;
    case (state)
      ST_IDLE: begin
        if (int_sync && int_enable) begin
          state_nxt  = ST_PULSE1;
          cnt_nxt    = LOW_LD;
          inta_n_nxt = 1'b0;
        end
      end
      ST_PULSE1: begin
        if (cnt_last) begin
          state_nxt  = ST_GAP;
          cnt_nxt    = GAP_LD;
          inta_n_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end
      ST_GAP: begin
        if (cnt_last) begin
          state_nxt    = ST_PULSE2;
          cnt_nxt      = LOW_LD;
          inta_n_nxt   = 1'b0;
          // INT already gone here means the PIC will answer with its default vector.
          spurious_nxt = !int_sync;
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end
      ST_PULSE2: begin
        if (cnt_last) begin
          state_nxt  = ST_HOLD;
          inta_n_nxt = 1'b1;
          vector_nxt = data_in;
          valid_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end
      ST_HOLD: begin
        if (vector_valid && vector_ready) begin
          state_nxt = ST_RECOVER;
          cnt_nxt   = REC_LD;
          valid_nxt = 1'b0;
        end
      end
      ST_RECOVER: begin
        // Lets the PIC drop INT and the synchroniser flush before re-arming.
        if (cnt_last) begin
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end
      default: begin
        state_nxt  = ST_IDLE;
        inta_n_nxt = 1'b1;
      end
    endcase
  end

endmodule
